ctrl_ajuste: RTL and testbench

Time-keeping and time-setting controller for the digital clock. It derives the 1 Hz seconds enable from the system clock and drives the seconds counter's enable input. It also runs a mode FSM driven by two push-buttons, RUN → SET_HOUR → SET_MIN, that issues single-cycle increment pulses to the hour and minute counters. It sits between the board buttons/oscillator and the seconds/minutes/hours counter chain.

---
 rtl/ctrl_ajuste.sv | 157 +++++++++++++++
 tb/tb_ctrl_ajuste.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_ajuste.sv
// -----------------------------------------------------------------------------
// ctrl_ajuste -- time-keeping / time-setting controller for the digital clock.
//
// Divides the system clock down to a 1 s tick that drives the seconds counter
// enable, and runs the RUN -> SET_HOUR -> SET_MIN mode FSM from two raw
// push-buttons, issuing single-cycle increment pulses to the hour and minute
// counters. Every output is registered.
//
// Ports:
//   ctrl_clock       in   system clock, rising edge
//   ctrl_reset       in   asynchronous active-low reset
//   ctrl_btn_mode    in   raw mode button (active-high, asynchronous)
//   ctrl_btn_inc     in   raw increment button (active-high, asynchronous)
//   ctrl_sec_enable  out  one-cycle pulse per second while in RUN
//   ctrl_sec_clear   out  one-cycle seconds-clear pulse on SET_MIN -> RUN
//   ctrl_min_inc     out  one-cycle minute increment pulse
//   ctrl_hour_inc    out  one-cycle hour increment pulse
//   ctrl_mode[1:0]   out  00 RUN, 01 SET_HOUR, 10 SET_MIN
//   ctrl_blink       out  blink for the field being set
// -----------------------------------------------------------------------------
module ctrl_ajuste #(
  parameter int unsigned TICK_DIV      = 50000000,
  parameter int unsigned TIMEOUT_TICKS = 10
) (
  input  logic       ctrl_clock,
  input  logic       ctrl_reset,
  input  logic       ctrl_btn_mode,
  input  logic       ctrl_btn_inc,
  output logic       ctrl_sec_enable,
  output logic       ctrl_sec_clear,
  output logic       ctrl_min_inc,
  output logic       ctrl_hour_inc,
  output logic [1:0] ctrl_mode,
  output logic       ctrl_blink
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TO_LIMIT   = TW'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          r_mode_s1, r_mode_s2, r_mode_s3;
  logic          r_inc_s1, r_inc_s2, r_inc_s3;
  logic [PW-1:0] r_presc;
  logic [TW-1:0] r_to_cnt;
  logic          r_sec_en, r_sec_clr, r_min_inc, r_hour_inc, r_blink;

  logic w_mode_edge, w_inc_edge, w_tick, w_timeout;
  logic w_hour_pulse, w_min_pulse, w_clr_pulse;
  logic w_enter_run, w_enter_set, w_in_set;

  // Third flop turns a held button into a single rising-edge strobe.
  assign w_mode_edge = r_mode_s2 & ~r_mode_s3;
  assign w_inc_edge  = r_inc_s2 & ~r_inc_s3;
  assign w_tick      = (r_presc == PRESC_LAST);
  assign w_in_set    = (r_state != ST_RUN);
  assign w_timeout   = w_in_set && (r_to_cnt == TO_LIMIT);
  assign w_enter_run = w_in_set && (w_next_state == ST_RUN);
  assign w_enter_set = (w_next_state != ST_RUN) && (w_next_state != r_state);

  // NOTE: every output of an always_comb gets a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_hour_pulse = 1'b0;
    w_min_pulse  = 1'b0;
    w_clr_pulse  = 1'b0;
    // Priority inside each SET state: mode edge, then inc edge, then timeout.
    // A button edge therefore beats a coincident timeout, and a coincident inc
    // is dropped when mode moves the FSM on.
    case (r_state)
      ST_RUN: begin
        if (w_mode_edge) w_next_state = ST_SET_HOUR;
      end
      ST_SET_HOUR: begin
        if (w_mode_edge)     w_next_state = ST_SET_MIN;
        else if (w_inc_edge) w_hour_pulse = 1'b1;
        else if (w_timeout)  w_next_state = ST_RUN;
      end
      ST_SET_MIN: begin
        if (w_mode_edge) begin
          w_next_state = ST_RUN;
          w_clr_pulse  = 1'b1;
        end else if (w_inc_edge) begin
          w_min_pulse = 1'b1;
        end else if (w_timeout) begin
          w_next_state = ST_RUN;
        end
      end
      default: w_next_state = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge ctrl_clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_state    <= ST_RUN;
      r_mode_s1  <= 1'b0;
      r_mode_s2  <= 1'b0;
      r_mode_s3  <= 1'b0;
      r_inc_s1   <= 1'b0;
      r_inc_s2   <= 1'b0;
      r_inc_s3   <= 1'b0;
      r_presc    <= '0;
      r_to_cnt   <= '0;
      r_sec_en   <= 1'b0;
      r_sec_clr  <= 1'b0;
      r_min_inc  <= 1'b0;
      r_hour_inc <= 1'b0;
      r_blink    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_mode_s1 <= ctrl_btn_mode;
      r_mode_s2 <= r_mode_s1;
      r_mode_s3 <= r_mode_s2;
      r_inc_s1  <= ctrl_btn_inc;
      r_inc_s2  <= r_inc_s1;
      r_inc_s3  <= r_inc_s2;

      // Restarting the prescaler on RUN entry gives a full second before the
      // first seconds enable after the time has been set.
      if (w_enter_run || w_tick) r_presc <= '0;
      else                       r_presc <= r_presc + PW'(1);

      if (w_mode_edge || w_inc_edge || w_enter_set || w_enter_run)
        r_to_cnt <= '0;
      else if (w_in_set && w_tick)
        r_to_cnt <= r_to_cnt + TW'(1);

      r_sec_en   <= w_tick && (r_state == ST_RUN);
      r_sec_clr  <= w_clr_pulse;
      r_min_inc  <= w_min_pulse;
      r_hour_inc <= w_hour_pulse;

      if (w_enter_run)            r_blink <= 1'b0;
      else if (w_enter_set)       r_blink <= 1'b1;
      else if (w_in_set && w_tick) r_blink <= ~r_blink;
    end
  end

  assign ctrl_sec_enable = r_sec_en;
  assign ctrl_sec_clear  = r_sec_clr;
  assign ctrl_min_inc    = r_min_inc;
  assign ctrl_hour_inc   = r_hour_inc;
  assign ctrl_mode       = r_state;
  assign ctrl_blink      = r_blink;

endmodule

// File: tb/tb_ctrl_ajuste.sv
// -----------------------------------------------------------------------------
// tb_ctrl_ajuste -- self-checking bench for ctrl_ajuste (TICK_DIV=4,
// TIMEOUT_TICKS=3). A per-cycle vector table covers idle RUN, hour setting,
// minute setting with the seconds clear, timeout return and simultaneous
// buttons; hand-written sequences cover a long held button and an
// asynchronous reset in the middle of a pulse.
//
// Table row r: inputs are applied before rising edge r (counted from reset
// release) and the expected outputs are those visible after that edge.
// Output word layout: {sec_enable, min_inc, hour_inc, sec_clear, mode[1:0],
// blink}.
// -----------------------------------------------------------------------------
module tb_ctrl_ajuste;

  localparam int NROWS = 82;
  localparam int B_SEC = 6;
  localparam int B_MIN = 5;
  localparam int B_HR  = 4;
  localparam int B_CLR = 3;

  typedef struct {
    logic       btn_mode;
    logic       btn_inc;
    logic [6:0] exp_out;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_mode, btn_inc;
  logic       sec_enable, sec_clear, min_inc, hour_inc, blink;
  logic [1:0] mode;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t vecs [1:NROWS];

  ctrl_ajuste #(
    .TICK_DIV      (4),
    .TIMEOUT_TICKS (3)
  ) dut (
    .ctrl_clock      (clk),
    .ctrl_reset      (rst_n),
    .ctrl_btn_mode   (btn_mode),
    .ctrl_btn_inc    (btn_inc),
    .ctrl_sec_enable (sec_enable),
    .ctrl_sec_clear  (sec_clear),
    .ctrl_min_inc    (min_inc),
    .ctrl_hour_inc   (hour_inc),
    .ctrl_mode       (mode),
    .ctrl_blink      (blink)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] pack_out();
    return {sec_enable, min_inc, hour_inc, sec_clear, mode, blink};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step();
    step();
    btn_mode = 1'b0;
  endtask

  task automatic set_mode_btn(input int a, input int b);
    for (int r = a; r <= b; r++) vecs[r].btn_mode = 1'b1;
  endtask

  task automatic set_inc_btn(input int a, input int b);
    for (int r = a; r <= b; r++) vecs[r].btn_inc = 1'b1;
  endtask

  task automatic set_state(input int a, input int b, input logic [1:0] m);
    for (int r = a; r <= b; r++) vecs[r].exp_out[2:1] = m;
  endtask

  task automatic set_blink(input int a, input int b);
    for (int r = a; r <= b; r++) vecs[r].exp_out[0] = 1'b1;
  endtask

  task automatic set_pulse(input int r, input int bit_idx);
    vecs[r].exp_out[bit_idx] = 1'b1;
  endtask

  initial begin
    int min_cnt;
    int hr_cnt;

    // ---------------- vector table ----------------
    for (int r = 1; r <= NROWS; r++) vecs[r] = '{1'b0, 1'b0, 7'd0};
    set_mode_btn(21, 22); set_mode_btn(33, 34); set_mode_btn(41, 42);
    set_mode_btn(48, 49); set_mode_btn(64, 65); set_mode_btn(68, 69);
    set_inc_btn(25, 26);  set_inc_btn(29, 30);  set_inc_btn(37, 38);
    set_inc_btn(68, 69);
    set_state(23, 34, 2'b01); set_state(35, 42, 2'b10);
    set_state(50, 59, 2'b01); set_state(66, 69, 2'b01);
    set_state(70, 80, 2'b10);
    set_blink(23, 23); set_blink(28, 31); set_blink(35, 35); set_blink(40, 42);
    set_blink(50, 50); set_blink(55, 58); set_blink(66, 67); set_blink(70, 71);
    set_blink(76, 79);
    set_pulse(4, B_SEC);  set_pulse(8, B_SEC);  set_pulse(12, B_SEC);
    set_pulse(16, B_SEC); set_pulse(20, B_SEC); set_pulse(47, B_SEC);
    set_pulse(64, B_SEC);
    set_pulse(27, B_HR);  set_pulse(31, B_HR);
    set_pulse(39, B_MIN);
    set_pulse(43, B_CLR);

    // ---------------- reset state ----------------
    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    #1;
    check("reset_outputs", 32'(pack_out()), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // ---------------- table-driven run ----------------
    for (int r = 1; r <= NROWS; r++) begin
      btn_mode = vecs[r].btn_mode;
      btn_inc  = vecs[r].btn_inc;
      step();
      check($sformatf("row%0d", r), 32'(pack_out()), 32'(vecs[r].exp_out));
    end
    btn_mode = 1'b0;
    btn_inc  = 1'b0;

    // ---------------- held inc in SET_MIN ----------------
    do_reset();
    press_mode();                    // rows 1-2
    step();                          // row 3
    check("hold_enter_set_hour", 32'(mode), 32'd1);
    press_mode();                    // rows 4-5
    step();                          // row 6
    check("hold_enter_set_min", 32'(mode), 32'd2);
    btn_inc = 1'b1;
    min_cnt = 0;
    hr_cnt  = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (min_inc)  min_cnt++;
      if (hour_inc) hr_cnt++;
    end
    btn_inc = 1'b0;
    check("hold_min_inc_count", 32'(min_cnt), 32'd1);
    check("hold_hour_inc_count", 32'(hr_cnt), 32'd0);
    check("hold_timeout_to_run", 32'(mode), 32'd0);

    // ---------------- reset in the middle of a pulse ----------------
    do_reset();
    press_mode();                    // rows 1-2
    step();                          // row 3
    press_mode();                    // rows 4-5
    step();                          // row 6
    check("midrst_set_min", 32'(mode), 32'd2);
    btn_inc = 1'b1;                  // rows 7-8
    step();
    step();
    btn_inc = 1'b0;
    step();                          // row 9: minute pulse visible
    check("midrst_pulse_high", 32'(min_inc), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_async_clear", 32'(pack_out()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("midrst_quiet%0d", c), 32'(pack_out()), 32'd0);
    end
    step();
    check("midrst_first_sec_enable", 32'(pack_out()), 32'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
